// File: rtl/mux_8x1_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for the 8:1 mux arbiter.
package mux_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, GRANT} state_e;

  // First set bit at ptr, ptr+1, ... ptr+7. Indices wrap mod 8 because the index is SEL_W bits wide.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/mux_8x1_rr_arbiter_if.sv
// Requester/downstream bundle of the shared mux arbiter.
interface mux_arb_if;
  import mux_arb_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] a;
  logic             out_ready;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             y;
  logic             y_valid;
  logic             busy;

  modport slave  (input req, a, out_ready, output gnt, sel, y, y_valid, busy);
  modport master (output req, a, out_ready, input gnt, sel, y, y_valid, busy);
endinterface

// File: rtl/mux_8x1_rr_arbiter_mux.sv
// Plain 8:1 bit multiplexer.
module mux_8x1
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] a,
  input  logic [SEL_W-1:0] s,
  output logic             y
);
  assign y = a[s];
endmodule

// File: rtl/mux_8x1_rr_arbiter.sv
// Round-robin arbiter time-sharing one 8:1 bit-mux; grants last at most MAX_BURST beats.
module mux_8x1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_arb_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  state_e           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0] w_pick;
  logic             w_req_sel, w_y_valid, w_xfer, w_last, w_y;

  assign w_pick    = rr_pick(bus.req, r_ptr);
  assign w_req_sel = bus.req[r_sel];
  assign w_y_valid = (r_state == GRANT) & w_req_sel;
  assign w_xfer    = w_y_valid & bus.out_ready;
  assign w_last    = (r_cnt == CNT_W'(MAX_BURST - 1));

  mux_8x1 u_mux (
    .a (bus.a),
    .s (r_sel),
    .y (w_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.req != '0) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = N_REQ'(1) << w_pick;
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // Withdrawal wins over a final beat: y_valid is already low, so no transfer.
        if (!w_req_sel || (w_xfer && w_last)) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_sel + SEL_W'(1);
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.sel     = r_sel;
  assign bus.y       = w_y;
  assign bus.y_valid = w_y_valid;
  assign bus.busy    = (r_state == GRANT);
endmodule

// File: tb/tb_mux_8x1_rr_arbiter.sv
// Directed bench for the round-robin mux arbiter.
module tb_mux_8x1_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] a_pat;
  logic [7:0] y_exp;

  mux_arb_if bus ();

  mux_8x1_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] req_v);
    rst_n = 1'b0;
    bus.req = req_v;
    bus.a = a_pat;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(8'hFF);
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.y_valid} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset gnt=%h sel=%0d busy=%b y_valid=%b, want 00/0/0/0",
               bus.gnt, bus.sel, bus.busy, bus.y_valid);
      errors++;
    end
    tick();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy} !== {8'h01, 3'd0, 1'b1}) begin
      $display("FAIL reset_first_grant gnt=%h sel=%0d busy=%b, want 01/0/1",
               bus.gnt, bus.sel, bus.busy);
      errors++;
    end
  endtask

  task automatic test_single;
    do_reset(8'h00);
    bus.req = 8'h04;
    tick();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({bus.gnt, bus.sel, bus.y, bus.y_valid} !== {8'h04, 3'd2, 1'b0, 1'b1}) begin
        $display("FAIL single_beat%0d gnt=%h sel=%0d y=%b vld=%b, want 04/2/0/1",
                 b, bus.gnt, bus.sel, bus.y, bus.y_valid);
        errors++;
      end
      tick();
    end
    checks++;
    if ({bus.gnt, bus.busy} !== {8'h00, 1'b0}) begin
      $display("FAIL single_bubble gnt=%h busy=%b, want 00/0", bus.gnt, bus.busy);
      errors++;
    end
    tick();
    checks++;
    if ({bus.gnt, bus.sel} !== {8'h04, 3'd2}) begin
      $display("FAIL single_regrant gnt=%h sel=%0d, want 04/2", bus.gnt, bus.sel);
      errors++;
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] g_exp;
    do_reset(8'h00);
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      g_exp = 8'h01 << (g % 8);
      tick();
      checks++;
      if ({bus.gnt, bus.sel} !== {g_exp, 3'(g % 8)}) begin
        $display("FAIL rr_grant%0d gnt=%h sel=%0d, want %h/%0d", g, bus.gnt, bus.sel, g_exp, g % 8);
        errors++;
      end
      for (int b = 0; b < 4; b++) begin
        checks++;
        if ({bus.y, bus.y_valid} !== {y_exp[g % 8], 1'b1}) begin
          $display("FAIL rr_y g%0d b%0d y=%b vld=%b, want %b/1", g, b, bus.y, bus.y_valid, y_exp[g % 8]);
          errors++;
        end
        tick();
      end
      checks++;
      if (bus.gnt !== 8'h00) begin
        $display("FAIL rr_bubble%0d gnt=%h, want 00", g, bus.gnt);
        errors++;
      end
    end
  endtask

  task automatic test_wrap;
    do_reset(8'h00);
    bus.req = 8'h80;
    tick();
    checks++;
    if (bus.gnt !== 8'h80) begin
      $display("FAIL wrap_first gnt=%h, want 80", bus.gnt);
      errors++;
    end
    repeat (4) tick();
    bus.req = 8'h81;
    tick();
    checks++;
    if ({bus.gnt, bus.sel} !== {8'h01, 3'd0}) begin
      $display("FAIL wrap_to0 gnt=%h sel=%0d, want 01/0", bus.gnt, bus.sel);
      errors++;
    end
    repeat (4) tick();
    tick();
    checks++;
    if ({bus.gnt, bus.sel} !== {8'h80, 3'd7}) begin
      $display("FAIL wrap_to7 gnt=%h sel=%0d, want 80/7", bus.gnt, bus.sel);
      errors++;
    end
  endtask

  task automatic test_backpressure;
    int xfers;
    xfers = 0;
    do_reset(8'h00);
    bus.req = 8'h04;
    tick();
    for (int c = 0; c < 7; c++) begin
      bus.out_ready = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if ({bus.gnt, bus.sel, bus.y_valid} !== {8'h04, 3'd2, 1'b1}) begin
        $display("FAIL bp_hold c%0d gnt=%h sel=%0d vld=%b, want 04/2/1", c, bus.gnt, bus.sel, bus.y_valid);
        errors++;
      end
      if (bus.y_valid && bus.out_ready) xfers++;
      tick();
    end
    checks++;
    if (xfers !== 4) begin
      $display("FAIL bp_count xfers=%0d, want 4", xfers);
      errors++;
    end
    checks++;
    if ({bus.gnt, bus.busy} !== {8'h00, 1'b0}) begin
      $display("FAIL bp_release gnt=%h busy=%b, want 00/0", bus.gnt, bus.busy);
      errors++;
    end
  endtask

  task automatic test_withdraw;
    do_reset(8'h00);
    bus.req = 8'h28;
    tick();
    checks++;
    if ({bus.gnt, bus.sel} !== {8'h08, 3'd3}) begin
      $display("FAIL wd_grant gnt=%h sel=%0d, want 08/3", bus.gnt, bus.sel);
      errors++;
    end
    repeat (2) tick();
    bus.req = 8'h20;
    #1;
    checks++;
    if ({bus.gnt, bus.y_valid} !== {8'h08, 1'b0}) begin
      $display("FAIL wd_valid gnt=%h vld=%b, want 08/0", bus.gnt, bus.y_valid);
      errors++;
    end
    tick();
    checks++;
    if ({bus.gnt, bus.busy} !== {8'h00, 1'b0}) begin
      $display("FAIL wd_release gnt=%h busy=%b, want 00/0", bus.gnt, bus.busy);
      errors++;
    end
    tick();
    checks++;
    if ({bus.gnt, bus.sel} !== {8'h20, 3'd5}) begin
      $display("FAIL wd_next gnt=%h sel=%0d, want 20/5", bus.gnt, bus.sel);
      errors++;
    end
  endtask

  initial begin
    a_pat = 8'b1010_1011;
    y_exp = 8'b1010_1011;
    bus.req = 8'hFF;
    bus.a = a_pat;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_withdraw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
